// File: rtl/mem_pkg.sv
// Shared types and defaults for the MEM-stage SRAM responder.
package mem_pkg;

    localparam int unsigned DefaultBaseAddr = 1024;
    localparam int unsigned DefaultSramAw   = 18;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } mem_state_e;

endpackage

// File: rtl/sram_dq_buf.sv
// Tristate pad driver for the 16-bit SRAM data bus.
module sram_dq_buf (
    input  logic        oe,
    input  logic [15:0] dout,
    output logic [15:0] din,
    inout  wire  [15:0] pad
);

    assign pad = oe ? dout : 16'bz;
    assign din = pad;

endmodule

// File: rtl/sram_mem_ctrl.sv
// Turns one 32-bit pipeline load/store into two 16-bit asynchronous SRAM accesses,
// holding ready low (pipeline freeze) until the access completes.
module sram_mem_ctrl
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'(DefaultBaseAddr),
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned SRAM_AW       = DefaultSramAw
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

    mem_state_e         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               is_wr_q, is_wr_d;
    logic [31:0]        data_q, data_d;
    logic [31:0]        read_data_q, read_data_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;

    logic [31:0]        eff;
    logic [15:0]        dq_in;
    logic [15:0]        dq_out;
    logic               dq_oe;
    logic               in_phase;
    logic               last;
    logic               unused_eff;

    // Sub-word byte offset and out-of-range bits are deliberately dropped.
    assign eff        = address - BASE_ADDR;
    assign unused_eff = ^{eff[31:SRAM_AW+1], eff[1:0]};

    assign in_phase = (state_q == LOW) || (state_q == HIGH);
    assign last     = (cnt_q == LastCnt);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        data_d      = data_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        unique case (state_q)
            IDLE: begin
                if (rd_en || wr_en) begin
                    state_d     = LOW;
                    cnt_d       = 4'd0;
                    is_wr_d     = wr_en;
                    data_d      = write_data;
                    sram_addr_d = {eff[SRAM_AW:2], 1'b0};
                end
            end
            LOW, HIGH: begin
                if (last) begin
                    cnt_d = 4'd0;
                    if (state_q == LOW) begin
                        state_d        = HIGH;
                        sram_addr_d[0] = 1'b1;
                        if (!is_wr_q) read_data_d[15:0] = dq_in;
                    end else begin
                        state_d = DONE;
                        if (!is_wr_q) read_data_d[31:16] = dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            is_wr_q     <= 1'b0;
            data_q      <= 32'd0;
            read_data_q <= 32'd0;
            sram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            data_q      <= data_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    // Strobes decode straight from state so an async reset releases the bus at once.
    // WE_N rises on the last cycle of a phase to give the SRAM a data-hold edge.
    always_comb begin
        dq_oe     = in_phase && is_wr_q;
        dq_out    = (state_q == HIGH) ? data_q[31:16] : data_q[15:0];
        SRAM_WE_N = !(dq_oe && !last);
        SRAM_OE_N = !(in_phase && !is_wr_q);
        ready     = (state_q == DONE) || ((state_q == IDLE) && !rd_en && !wr_en);
    end

    assign read_data = read_data_q;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    sram_dq_buf u_dq_buf (
        .oe   (dq_oe),
        .dout (dq_out),
        .din  (dq_in),
        .pad  (SRAM_DQ)
    );

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Randomised load/store bench for sram_mem_ctrl against a word-level memory model.
module tb_sram_mem_ctrl;

    localparam int Ac  = 2;
    localparam int Ac3 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    logic        wr3;
    logic [31:0] addr3, wd3, rdata3;
    logic        rdy3;
    wire  [15:0] sram_dq3;
    logic [17:0] addr_o3;
    logic        we_n3, oe_n3, ce3, ub3, lb3;

    logic [15:0] mem [0:262143];
    logic        prev_we_n;
    logic        probe_en;
    logic [15:0] probe_val;

    logic [31:0] ref_mem [int unsigned];
    logic [31:0] rd_exp;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    sram_mem_ctrl #(.ACCESS_CYCLES(Ac)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (we_n),
        .SRAM_OE_N  (oe_n),
        .SRAM_CE_N  (ce_n),
        .SRAM_UB_N  (ub_n),
        .SRAM_LB_N  (lb_n)
    );

    sram_mem_ctrl #(.ACCESS_CYCLES(Ac3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (1'b0),
        .wr_en      (wr3),
        .address    (addr3),
        .write_data (wd3),
        .read_data  (rdata3),
        .ready      (rdy3),
        .SRAM_DQ    (sram_dq3),
        .SRAM_ADDR  (addr_o3),
        .SRAM_WE_N  (we_n3),
        .SRAM_OE_N  (oe_n3),
        .SRAM_CE_N  (ce3),
        .SRAM_UB_N  (ub3),
        .SRAM_LB_N  (lb3)
    );

    // Asynchronous SRAM: reads drive the bus while OE_N is low, writes commit on WE_N rising.
    assign sram_dq = probe_en ? probe_val : ((!oe_n && we_n) ? mem[sram_addr] : 16'bz);

    always @(negedge clk) begin
        if (rst) begin
            prev_we_n <= 1'b1;
        end else begin
            if (we_n && !prev_we_n && oe_n) mem[sram_addr] <= sram_dq;
            prev_we_n <= we_n;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int unsigned word_of(input logic [31:0] a);
        logic [31:0] e;
        e = a - 32'd1024;
        return 32'(e[18:2]);
    endfunction

    function automatic logic [31:0] ref_rd(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'd0;
    endfunction

    task automatic check_z(input string tag);
        probe_en  = 1'b1;
        probe_val = 16'h5a5a;
        #1;
        check_eq(tag, 32'(sram_dq), 32'h5a5a);
        probe_en = 1'b0;
    endtask

    task automatic access(input bit sel, input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] wd, input bit drop, input string tag);
        int          ac, lat, pos;
        logic [17:0] lo;
        logic        e_we;
        int unsigned w;
        ac  = sel ? Ac3 : Ac;
        w   = word_of(a);
        lo  = 18'(w) << 1;
        lat = -1;
        @(posedge clk); #1;
        if (sel) begin
            wr3 = wr; addr3 = a; wd3 = wd;
        end else begin
            rd_en = rd; wr_en = wr; address = a; write_data = wd;
        end
        for (int i = 0; i < 64 && lat < 0; i++) begin
            @(negedge clk);
            if (sel ? rdy3 : ready) begin
                lat = i;
            end else if (i >= 1) begin
                pos  = (i - 1) % ac;
                e_we = wr ? (pos == ac - 1) : 1'b1;
                check_eq({tag, "_addr"}, 32'(sel ? addr_o3 : sram_addr), 32'(lo | 18'(i > ac)));
                check_eq({tag, "_we_n"}, 32'(sel ? we_n3 : we_n), 32'(e_we));
                check_eq({tag, "_oe_n"}, 32'(sel ? oe_n3 : oe_n), 32'(wr));
            end
            if (drop && i == 1) begin
                @(posedge clk); #1;
                rd_en = 1'b0;
            end
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(2 * ac + 1));
        if (!sel) begin
            if (wr) begin
                ref_mem[w] = wd;
                check_eq({tag, "_mem_lo"}, 32'(mem[lo]), 32'(wd[15:0]));
                check_eq({tag, "_mem_hi"}, 32'(mem[lo | 18'd1]), 32'(wd[31:16]));
            end else begin
                rd_exp = ref_rd(w);
            end
            check_eq({tag, "_rdata"}, read_data, rd_exp);
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0; wr3 = 1'b0;
        @(negedge clk);
        check_eq({tag, "_idle_rdy"}, 32'(sel ? rdy3 : ready), 32'd1);
    endtask

    initial begin
        int          op, per;
        logic [31:0] a, wd, old;
        int unsigned w;

        for (int i = 0; i < 262144; i++) mem[i] = 16'd0;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
        wr3 = 1'b0; addr3 = 32'd0; wd3 = 32'd0; probe_en = 1'b0; probe_val = 16'd0;
        rd_exp = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_we_n", 32'(we_n), 32'd1);
        check_eq("rst_oe_n", 32'(oe_n), 32'd1);
        check_eq("rst_rdata", read_data, 32'd0);
        check_eq("rst_addr", 32'(sram_addr), 32'd0);
        check_eq("tie_offs", 32'({ce_n, ub_n, lb_n, ce3, ub3, lb3}), 32'd0);
        check_z("rst_dq_z");

        access(0, 1, 0, 32'd1024, 32'hdeadbeef, 0, "st1024");
        access(0, 0, 1, 32'd1024, 32'd0, 0, "ld1024");
        access(1, 1, 0, 32'd1032, 32'h0badf00d, 0, "ac3_1032");
        access(1, 1, 0, 32'd1020, 32'h11112222, 0, "ac3_1020");
        access(0, 1, 0, 32'd1020, 32'h55aa66bb, 0, "st1020");
        access(0, 0, 1, 32'd1020, 32'd0, 0, "ld1020");
        check_eq("wrap_hi_word", 32'(mem[18'h3ffff]), 32'h55aa);
        access(0, 1, 1, 32'd1028, 32'h12345678, 0, "conflict");
        access(0, 0, 1, 32'd1028, 32'd0, 1, "ld_drop");

        // Reset during the first HIGH cycle of a store: only the low half may land.
        a   = 32'd1040;
        wd  = 32'hcafef00d;
        w   = word_of(a);
        old = ref_rd(w);
        @(posedge clk); #1;
        wr_en = 1'b1; address = a; write_data = wd;
        repeat (3) @(posedge clk);
        #2;
        check_eq("mid_we_low", 32'(we_n), 32'd0);
        check_eq("mid_addr_hi", 32'(sram_addr), 32'((18'(w) << 1) | 18'd1));
        rst = 1'b1; wr_en = 1'b0;
        #1;
        check_eq("mid_rst_we_n", 32'(we_n), 32'd1);
        check_eq("mid_rst_oe_n", 32'(oe_n), 32'd1);
        check_eq("mid_rst_ready", 32'(ready), 32'd1);
        check_z("mid_rst_dq_z");
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        rd_exp    = 32'd0;
        ref_mem[w] = {old[31:16], wd[15:0]};
        @(negedge clk);
        check_eq("mid_rst_rdata", read_data, 32'd0);
        check_eq("mid_mem_lo", 32'(mem[18'(w) << 1]), 32'(wd[15:0]));
        check_eq("mid_mem_hi", 32'(mem[(18'(w) << 1) | 18'd1]), 32'(old[31:16]));
        access(0, 0, 1, a, 32'd0, 0, "ld_after_rst");

        for (int it = 0; it < 24; it++) begin
            op = int'($urandom_range(0, 3));
            a  = (it % 5 == 4) ? $urandom : 32'd1024 + 32'(4 * $urandom_range(0, 7));
            wd = $urandom;
            access(0, op >= 2, op != 2, a, wd, 0, "rand");
        end

        // Back-to-back loads with rd_en held high.
        per = 2 * Ac + 2;
        @(posedge clk); #1;
        rd_en = 1'b1; wr_en = 1'b0; address = 32'd1024;
        for (int i = 0; i < 2 * per; i++) begin
            int j, k;
            k = i / per;
            j = i % per;
            w = word_of(k == 0 ? 32'd1024 : 32'd1028);
            @(negedge clk);
            check_eq("b2b_ready", 32'(ready), 32'(j == 2 * Ac + 1));
            if (j >= 1 && j <= 2 * Ac)
                check_eq("b2b_addr", 32'(sram_addr), 32'((18'(w) << 1) | 18'(j > Ac)));
            if (j == 2 * Ac + 1) begin
                rd_exp = ref_rd(w);
                check_eq("b2b_rdata", read_data, rd_exp);
                if (k == 0) begin
                    @(posedge clk); #1;
                    address = 32'd1028;
                end
            end
        end
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(negedge clk);
        check_eq("b2b_end_ready", 32'(ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
